// File: rtl/cache_ctrl_wb.sv
// -----------------------------------------------------------------------------
// cache_ctrl_wb
// Control FSM for a set-associative write-back cache with tree pseudo-LRU
// replacement. The tag/data arrays live outside this block; it decides hit
// handling, victim selection, writeback and refill bursts, and the tag update.
//
// Ports
//   CLK, reset            clock, synchronous active-high reset
//   rden, wen             CPU read / write request (both high = write)
//   set_idx               set of the current request
//   hit, hit_way          tag compare result for set_idx
//   line_valid/dirty      valid / dirty bits of the addressed set
//   mem_ready             memory accepted/returned the current beat
//   stall                 CPU must hold its request
//   victim_way            way chosen for writeback/refill
//   mem_rd, mem_wr        refill read / writeback burst active
//   beat                  current beat index within the burst
//   fill_we               write returned beat into data[victim_way][beat]
//   tag_we                write tag, set valid, clear dirty for victim_way
//   dirty_set             mark hit_way dirty
//   done                  one-cycle pulse on request completion
// -----------------------------------------------------------------------------
module cache_ctrl_wb #(
  parameter int WAYS  = 2,
  parameter int SETS  = 16,
  parameter int BEATS = 4,
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int SET_W  = $clog2(SETS),
  localparam int BEAT_W = $clog2(BEATS)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              rden,
  input  logic              wen,
  input  logic [SET_W-1:0]  set_idx,
  input  logic              hit,
  input  logic [WAY_W-1:0]  hit_way,
  input  logic [WAYS-1:0]   line_valid,
  input  logic [WAYS-1:0]   line_dirty,
  input  logic              mem_ready,
  output logic              stall,
  output logic [WAY_W-1:0]  victim_way,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [BEAT_W-1:0] beat,
  output logic              fill_we,
  output logic              tag_we,
  output logic              dirty_set,
  output logic              done
);

  localparam int LOG_W  = $clog2(WAYS);
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL, UPDATE} state_e;

  state_e              state_q, state_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic                is_write_q, is_write_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic                plru_we;
  logic [WAY_W-1:0]    plru_way;
  logic [WAY_W-1:0]    plru_victim;

  // Tree nodes are heap-ordered (node n has children 2n+1 / 2n+2); a node bit
  // of 0 steers the victim search into the left subtree.
  function automatic logic [WAY_W-1:0] plru_pick(input logic [PLRU_W-1:0] t);
    logic [WAY_W-1:0]  w;
    logic [PLRU_W-1:0] sh;
    int                node;
    w    = '0;
    node = 0;
    for (int l = 0; l < LOG_W; l++) begin
      sh   = t >> node;
      w    = (w << 1) | WAY_W'(sh[0]);
      node = 2 * node + 1 + (sh[0] ? 1 : 0);
    end
    return w;
  endfunction

  // Point every node on the path to way w away from w.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] t,
                                                   input logic [WAY_W-1:0]  w);
    logic [PLRU_W-1:0] r;
    logic [WAY_W-1:0]  sw;
    int                node;
    r    = t;
    node = 0;
    for (int l = 0; l < LOG_W; l++) begin
      sw   = w >> (LOG_W - 1 - l);
      r    = sw[0] ? (r & ~(PLRU_W'(1) << node)) : (r | (PLRU_W'(1) << node));
      node = 2 * node + 1 + (sw[0] ? 1 : 0);
    end
    return r;
  endfunction

  // Lowest-index invalid way; MSB of the result flags that one exists.
  function automatic logic [WAY_W:0] find_invalid(input logic [WAYS-1:0] v);
    logic [WAY_W:0]  r;
    logic [WAYS-1:0] vs;
    r = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      vs = v >> i;
      if (!vs[0]) r = {1'b1, WAY_W'(i)};
    end
    return r;
  endfunction

  function automatic logic needs_writeback(input logic [WAYS-1:0]  v,
                                           input logic [WAYS-1:0]  d,
                                           input logic [WAY_W-1:0] w);
    logic [WAYS-1:0] dv;
    dv = (v & d) >> w;
    return dv[0];
  endfunction

  generate
    if (WAYS > 1) begin : g_plru
      logic [PLRU_W-1:0] plru_q [SETS];

      always_ff @(posedge CLK) begin
        if (reset) begin
          for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else if (plru_we) begin
          plru_q[set_q] <= plru_touch(plru_q[set_q], plru_way);
        end
      end

      assign plru_victim = plru_pick(plru_q[set_q]);
    end else begin : g_no_plru
      assign plru_victim = '0;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      victim_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      beat_q   <= beat_d;
    end
  end

  // Request capture is datapath only; its value is irrelevant while IDLE.
  always_ff @(posedge CLK) begin
    set_q      <= set_d;
    is_write_q <= is_write_d;
  end

  always_comb begin
    logic [WAY_W:0] inv;
    state_d    = state_q;
    set_d      = set_q;
    is_write_d = is_write_q;
    victim_d   = victim_q;
    beat_d     = beat_q;
    stall      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    fill_we    = 1'b0;
    tag_we     = 1'b0;
    dirty_set  = 1'b0;
    done       = 1'b0;
    plru_we    = 1'b0;
    plru_way   = hit_way;
    inv        = find_invalid(line_valid);

    unique case (state_q)
      IDLE: begin
        if (rden || wen) begin
          set_d      = set_idx;
          is_write_d = wen;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          done      = 1'b1;
          dirty_set = is_write_q;
          plru_we   = 1'b1;
          state_d   = IDLE;
        end else begin
          stall    = 1'b1;
          victim_d = inv[WAY_W] ? inv[WAY_W-1:0] : plru_victim;
          beat_d   = '0;
          state_d  = needs_writeback(line_valid, line_dirty, victim_d) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        stall  = 1'b1;
        mem_wr = 1'b1;
        if (mem_ready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) state_d = REFILL;
        end
      end
      REFILL: begin
        stall   = 1'b1;
        mem_rd  = 1'b1;
        fill_we = mem_ready;
        if (mem_ready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) state_d = UPDATE;
        end
      end
      UPDATE: begin
        stall    = 1'b1;
        tag_we   = 1'b1;
        plru_we  = 1'b1;
        plru_way = victim_q;
        state_d  = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign victim_way = victim_q;
  assign beat       = beat_q;

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl_wb
// Bench for cache_ctrl_wb (WAYS=2, SETS=4, BEATS=4). A small tag-array model
// stands in for the cache arrays and answers hit/line_valid/line_dirty; a
// reference model (last-used way per set, lowest invalid way first) predicts
// the victim, the burst shape and the completion of every request.
// -----------------------------------------------------------------------------
module tb_cache_ctrl_wb;

  logic       CLK = 1'b0;
  logic       reset;
  logic       rden, wen;
  logic [1:0] set_idx;
  logic       hit;
  logic [0:0] hit_way;
  logic [1:0] line_valid, line_dirty;
  logic       mem_ready;
  logic       stall;
  logic [0:0] victim_way;
  logic       mem_rd, mem_wr;
  logic [1:0] beat;
  logic       fill_we, tag_we, dirty_set, done;

  cache_ctrl_wb #(.WAYS(2), .SETS(4), .BEATS(4)) dut (
    .CLK(CLK), .reset(reset), .rden(rden), .wen(wen), .set_idx(set_idx),
    .hit(hit), .hit_way(hit_way), .line_valid(line_valid), .line_dirty(line_dirty),
    .mem_ready(mem_ready), .stall(stall), .victim_way(victim_way),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .beat(beat), .fill_we(fill_we),
    .tag_we(tag_we), .dirty_set(dirty_set), .done(done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Cache array environment
  int env_tag   [4][2];
  bit env_valid [4][2];
  bit env_dirty [4][2];
  // Reference replacement state: last way touched per set, -1 = none since reset
  int last_used [4];

  int cur_set, cur_tag;
  bit rand_ready = 1'b0;

  // Observations of one request
  int obs_cycles, obs_stall, obs_wr, obs_rd, obs_fill, obs_tw, obs_done, obs_victim;
  bit obs_ok, obs_both, obs_ds, obs_bp_ok;

  function automatic int model_victim(input int s);
    for (int w = 0; w < 2; w++) if (!env_valid[s][w]) return w;
    return (last_used[s] < 0) ? 0 : 1 - last_used[s];
  endfunction

  function automatic int model_hit_way(input int s, input int tag);
    for (int w = 0; w < 2; w++) if (env_valid[s][w] && env_tag[s][w] == tag) return w;
    return -1;
  endfunction

  function automatic logic [63:0] pack(input int v, input int wrb, input int rdb,
                                       input int fil, input int tw, input int dn,
                                       input int cyc, input bit ok, input bit both,
                                       input bit ds);
    return {8'h0, 4'(v), 8'(wrb), 8'(rdb), 8'(fil), 4'(tw), 4'(dn), 8'(cyc),
            4'(ok), 4'(both), 4'(ds)};
  endfunction

  task automatic env_drive();
    int hw;
    hw = model_hit_way(cur_set, cur_tag);
    set_idx    = 2'(cur_set);
    hit        = (hw >= 0);
    hit_way    = 1'(hw < 0 ? 0 : hw);
    line_valid = {env_valid[cur_set][1], env_valid[cur_set][0]};
    line_dirty = {env_dirty[cur_set][1], env_dirty[cur_set][0]};
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) last_used[s] = -1;
  endtask

  // Issue one request and record what the DUT does until done (bounded).
  // Entered and left one time unit after a rising edge.
  task automatic run_req(input bit wr, input int s, input int tag, input int bp_len);
    bit fin, tw_now, dn_now, ds_now, bp_active;
    int tw_way, bp_cnt;
    obs_cycles = 0; obs_stall = 0; obs_wr = 0; obs_rd = 0; obs_fill = 0;
    obs_tw = 0; obs_done = 0; obs_victim = -1; obs_ok = 1; obs_both = 0;
    obs_ds = 0; obs_bp_ok = 1;
    fin = 0; bp_cnt = 0; bp_active = 0; tw_way = 0;
    cur_set = s; cur_tag = tag;
    wen  = wr;
    rden = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_ready = 1'b1;
    env_drive();
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge CLK);
      obs_cycles++;
      tw_now = tag_we; dn_now = done; ds_now = dirty_set;
      if (stall) obs_stall++;
      if (mem_rd && mem_wr) obs_both = 1;
      if (mem_wr && mem_ready) begin
        if (int'(beat) != obs_wr % 4 || obs_rd != 0) obs_ok = 0;
        obs_wr++;
      end
      if (mem_rd && mem_ready) begin
        if (int'(beat) != obs_rd % 4) obs_ok = 0;
        obs_rd++;
      end
      if (fill_we) begin
        if (!mem_rd || int'(beat) != obs_fill % 4) obs_ok = 0;
        obs_fill++;
      end
      if (dirty_set && !done) obs_ok = 0;
      if (tag_we) begin obs_tw++; obs_victim = int'(victim_way); tw_way = int'(victim_way); end
      if (done) begin obs_done++; obs_ds = dirty_set; fin = 1; end
      if (bp_active && (beat != 2'd2 || fill_we || !mem_rd)) obs_bp_ok = 0;
      @(posedge CLK); #1;
      if (tw_now) begin
        env_tag[s][tw_way] = tag; env_valid[s][tw_way] = 1; env_dirty[s][tw_way] = 0;
      end
      if (dn_now && ds_now) env_dirty[s][hit_way] = 1;
      if (fin) begin
        rden = 0; wen = 0;
      end else begin
        env_drive();
        bp_active = 0;
        if (bp_len > 0 && mem_rd && beat == 2'd2 && bp_cnt < bp_len) begin
          mem_ready = 0; bp_cnt++; bp_active = 1;
        end else if (rand_ready) begin
          mem_ready = ($urandom_range(0, 3) != 0);
        end else begin
          mem_ready = 1;
        end
      end
    end
    if (!fin) obs_ok = 0;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    reset = 1;
    rden = 1'($urandom); wen = 1'($urandom); set_idx = 2'($urandom);
    hit = 1'($urandom); hit_way = 1'($urandom); line_valid = 2'($urandom);
    line_dirty = 2'($urandom); mem_ready = 1'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      got = {stall, victim_way, mem_rd, mem_wr, beat, fill_we, tag_we, dirty_set, done, 2'b00};
      checks++;
      if (got !== 12'h0) begin
        errors++; $display("FAIL reset_outputs cycle %0d got %h want 000", i, got);
      end
    end
    reset = 0; rden = 0; wen = 0; hit = 0; mem_ready = 1;
    model_reset();
    @(posedge CLK); #1;
  endtask

  task automatic test_hit(input bit wr);
    logic [63:0] got, exp;
    env_valid[1][0] = 1; env_tag[1][0] = 4;
    run_req(wr, 1, 4, 0);
    last_used[1] = 0;
    got = pack(obs_victim, obs_wr, obs_rd, obs_fill, obs_tw, obs_done, obs_cycles, obs_ok, obs_both, obs_ds);
    exp = pack(-1, 0, 0, 0, 0, 1, 2, 1, 0, wr);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL hit wr=%0d got %h want %h", wr, got, exp); end
    checks++;
    if (obs_stall !== 0) begin errors++; $display("FAIL hit_stall got %0d want 0", obs_stall); end
  endtask

  task automatic test_clean_miss();
    logic [63:0] got, exp;
    // set 1 now holds way0 only (valid=01); way1 must be filled
    run_req(0, 1, 9, 0);
    got = pack(obs_victim, obs_wr, obs_rd, obs_fill, obs_tw, obs_done, obs_cycles, obs_ok, obs_both, obs_ds);
    exp = pack(1, 0, 4, 4, 1, 1, 8, 1, 0, 0);
    last_used[1] = 1;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL clean_miss got %h want %h", got, exp); end
    checks++;
    if (obs_stall !== 6) begin errors++; $display("FAIL clean_miss_stall got %0d want 6", obs_stall); end
  endtask

  task automatic test_dirty_miss();
    logic [63:0] got, exp;
    for (int w = 0; w < 2; w++) begin
      env_valid[2][w] = 1; env_dirty[2][w] = 1; env_tag[2][w] = 5 + w;
    end
    run_req(0, 2, 7, 0);
    got = pack(obs_victim, obs_wr, obs_rd, obs_fill, obs_tw, obs_done, obs_cycles, obs_ok, obs_both, obs_ds);
    exp = pack(0, 4, 4, 4, 1, 1, 12, 1, 0, 0);
    last_used[2] = 0;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL dirty_miss got %h want %h", got, exp); end
    run_req(1, 2, 8, 0);
    got = pack(obs_victim, obs_wr, obs_rd, obs_fill, obs_tw, obs_done, obs_cycles, obs_ok, obs_both, obs_ds);
    exp = pack(1, 4, 4, 4, 1, 1, 12, 1, 0, 1);
    last_used[2] = 1;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL dirty_miss_second got %h want %h", got, exp); end
  endtask

  task automatic test_backpressure();
    logic [63:0] got, exp;
    run_req(0, 0, 3, 3);
    got = pack(obs_victim, obs_wr, obs_rd, obs_fill, obs_tw, obs_done, obs_cycles, obs_ok, obs_both, obs_ds);
    exp = pack(0, 0, 4, 4, 1, 1, 11, 1, 0, 0);
    last_used[0] = 0;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL backpressure got %h want %h", got, exp); end
    checks++;
    if (obs_bp_ok !== 1'b1) begin errors++; $display("FAIL backpressure_hold got %0d want 1", obs_bp_ok); end
  endtask

  task automatic test_reset_mid_refill();
    logic [63:0] got, exp;
    bit reached, bad;
    // touch way 0 of set 2 so an uncleared PLRU would point at way 1
    run_req(0, 2, 7, 0);
    last_used[2] = 0;
    cur_set = 3; cur_tag = 1; rden = 1; wen = 0; mem_ready = 1;
    env_drive();
    reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      @(posedge CLK); #1;
      env_drive();
      if (mem_rd && beat == 2'd2) reached = 1;
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL mid_refill_reach got 0 want 1"); end
    reset = 1; rden = 0;
    @(posedge CLK); #1;
    reset = 0;
    model_reset();
    checks++;
    if ({mem_rd, mem_wr, tag_we, stall, beat} !== 6'h0) begin
      errors++; $display("FAIL mid_refill_abort got %h want 00", {mem_rd, mem_wr, tag_we, stall, beat});
    end
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (tag_we || mem_rd || mem_wr) bad = 1;
    end
    @(posedge CLK); #1;
    checks++;
    if (bad) begin errors++; $display("FAIL mid_refill_quiet got 1 want 0"); end
    run_req(0, 2, 10, 0);
    got = pack(obs_victim, obs_wr, obs_rd, obs_fill, obs_tw, obs_done, obs_cycles, obs_ok, obs_both, obs_ds);
    exp = pack(0, 0, 4, 4, 1, 1, 8, 1, 0, 0);
    last_used[2] = 0;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL plru_cleared got %h want %h", got, exp); end
  endtask

  task automatic test_random();
    logic [63:0] got, exp;
    int s, tag, hw, v, wbb;
    bit wr;
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      s = $urandom_range(0, 3); tag = $urandom_range(0, 2); wr = 1'($urandom);
      hw = model_hit_way(s, tag);
      v = model_victim(s);
      wbb = (hw < 0 && env_valid[s][v] && env_dirty[s][v]) ? 4 : 0;
      run_req(wr, s, tag, 0);
      got = pack(obs_victim, obs_wr, obs_rd, obs_fill, obs_tw, obs_done, 0, obs_ok, obs_both, obs_ds);
      if (hw >= 0) exp = pack(-1, 0, 0, 0, 0, 1, 0, 1, 0, wr);
      else         exp = pack(v, wbb, 4, 4, 1, 1, 0, 1, 0, wr);
      last_used[s] = (hw >= 0) ? hw : v;
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random #%0d set %0d tag %0d got %h want %h", n, s, tag, got, exp);
      end
      checks++;
      if (obs_stall !== ((hw >= 0) ? 0 : obs_cycles - 2)) begin
        errors++; $display("FAIL random_stall #%0d got %0d cycles %0d", n, obs_stall, obs_cycles);
      end
    end
    rand_ready = 0;
  endtask

  initial begin
    reset = 1; rden = 0; wen = 0; set_idx = 0; hit = 0; hit_way = 0;
    line_valid = 0; line_dirty = 0; mem_ready = 1;
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        env_tag[s][w] = 0; env_valid[s][w] = 0; env_dirty[s][w] = 0;
      end
    model_reset();
    test_reset();
    test_hit(0);
    test_hit(1);
    test_clean_miss();
    test_dirty_miss();
    test_backpressure();
    test_reset_mid_refill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
